regfile_wr_arbiter: RTL and testbench

Shares the single write port of the 8-entry x 64-bit core register file between several writeback requesters (ALU writeback, load return, host/debug port) using round-robin arbitration with a valid/ready handshake. It also sequences a hardware clear sweep that zeroes all registers on demand, because the register array itself holds no reset-clearable state across the asynchronous reset domain. The block sits between the execute/memory writeback stages and the register file's `waddr`/`wdata`/`wena` inputs.

---
 rtl/regfile_wr_arbiter.sv | 140 ++++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the shared register-file write port, with a hardware
// clear sweep that writes zero to every register on demand.
module regfile_wr_arbiter #(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     clear_start,
  output logic                     clear_busy,
  output logic                     clear_done,
  output logic [ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic                     rf_wena,
  output logic [1:0]               grant_id
);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e              r_state, w_state_nxt;
  logic [2:0]          r_cnt;
  logic [1:0]          r_ptr;
  logic [ADDR_W-1:0]   r_waddr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_wena;
  logic [1:0]          r_gid;
  logic                r_done;

  logic [ADDR_W-1:0]   w_addr_arr [NREQ];
  logic [DATA_W-1:0]   w_data_arr [NREQ];
  logic                w_found;
  logic [1:0]          w_win;
  logic [1:0]          w_idx;
  logic [1:0]          w_ptr_nxt;
  logic                w_xfer;
  logic                w_sweep_last;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    assign w_data_arr[g] = req_data[g*DATA_W +: DATA_W];
  end

  // First valid requester scanning upward from the round-robin pointer.
  always_comb begin
    w_found = 1'b0;
    w_win   = 2'd0;
    w_idx   = 2'd0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = 2'((32'(r_ptr) + k) % NREQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_ptr_nxt    = (w_win == 2'(NREQ - 1)) ? 2'd0 : w_win + 2'd1;
  assign w_xfer       = |req_ready;
  // Counter has wrapped past 7, so the last sweep write is on the port now.
  assign w_sweep_last = (r_cnt == 3'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:  if (clear_start)  w_state_nxt = StClear;
      StClear: if (w_sweep_last) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    clear_busy = (r_state == StClear);
    if (reset && (r_state == StIdle) && !clear_start && w_found) begin
      req_ready[w_win] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= 3'd0;
      r_ptr   <= 2'd0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_wena  <= 1'b0;
      r_gid   <= 2'd0;
      r_done  <= 1'b0;
    end else begin
      r_wena <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (clear_start) begin
            r_waddr <= '0;
            r_wdata <= '0;
            r_wena  <= 1'b1;
            r_cnt   <= 3'd1;
          end else if (w_xfer) begin
            r_waddr <= w_addr_arr[w_win];
            r_wdata <= w_data_arr[w_win];
            r_wena  <= 1'b1;
            r_gid   <= w_win;
            r_ptr   <= w_ptr_nxt;
          end
        end
        StClear: begin
          if (w_sweep_last) begin
            r_done <= 1'b1;
          end else begin
            r_waddr <= ADDR_W'(r_cnt);
            r_wdata <= '0;
            r_wena  <= 1'b1;
            r_cnt   <= r_cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rf_waddr   = r_waddr;
  assign rf_wdata   = r_wdata;
  assign rf_wena    = r_wena;
  assign grant_id   = r_gid;
  assign clear_done = r_done;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios plus randomized traffic checked
// against a cycle-level reference model of the arbitration and sweep rules.
module tb_regfile_wr_arbiter;
  localparam int NREQ   = 3;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 64;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   clear_start;
  logic                   clear_busy;
  logic                   clear_done;
  logic [ADDR_W-1:0]      rf_waddr;
  logic [DATA_W-1:0]      rf_wdata;
  logic                   rf_wena;
  logic [1:0]             grant_id;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int              m_ptr;
  bit              m_in_sweep;
  int              m_sweep_q[$];
  logic            e_wena;
  logic [2:0]      e_waddr;
  logic [63:0]     e_wdata;
  logic [1:0]      e_gid;
  logic            e_done;

  regfile_wr_arbiter #(
    .NREQ   (NREQ),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .rf_wena     (rf_wena),
    .grant_id    (grant_id)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] exp_ready();
    if (reset !== 1'b1 || m_in_sweep || clear_start) return 3'b000;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (req_valid[i]) return 3'(1 << i);
    end
    return 3'b000;
  endfunction

  function automatic logic [71:0] exp_regs();
    return {e_wena, e_waddr, e_wdata, e_gid, m_in_sweep, e_done};
  endfunction

  function automatic logic [71:0] obs_regs();
    return {rf_wena, rf_waddr, rf_wdata, grant_id, clear_busy, clear_done};
  endfunction

  task automatic model_reset();
    m_ptr      = 0;
    m_in_sweep = 0;
    m_sweep_q.delete();
    e_wena  = 1'b0;
    e_waddr = '0;
    e_wdata = '0;
    e_gid   = '0;
    e_done  = 1'b0;
  endtask

  // Advance one clock edge, apply the reference rules, land at posedge+1.
  task automatic tick(output logic [2:0] acc);
    logic [2:0] r;
    r   = exp_ready();
    acc = r;
    @(posedge clk);
    if (m_in_sweep) begin
      if (m_sweep_q.size() > 0) begin
        e_waddr = 3'(m_sweep_q.pop_front());
        e_wdata = '0;
        e_wena  = 1'b1;
        e_done  = 1'b0;
      end else begin
        m_in_sweep = 0;
        e_wena     = 1'b0;
        e_done     = 1'b1;
      end
    end else if (clear_start) begin
      m_in_sweep = 1;
      m_sweep_q.delete();
      for (int a = 1; a < 8; a++) m_sweep_q.push_back(a);
      e_waddr = '0;
      e_wdata = '0;
      e_wena  = 1'b1;
      e_done  = 1'b0;
    end else begin
      e_done = 1'b0;
      e_wena = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (r[i]) begin
          e_waddr = req_addr[i*ADDR_W +: ADDR_W];
          e_wdata = req_data[i*DATA_W +: DATA_W];
          e_wena  = 1'b1;
          e_gid   = 2'(i);
          m_ptr   = (i + 1) % NREQ;
        end
      end
    end
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    model_reset();
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [2:0] acc;
    reset = 1'b0;
    req_valid = '0; req_addr = '0; req_data = '0; clear_start = 1'b0;
    model_reset();
    @(posedge clk); #1;
    n_tests++;
    if (obs_regs() !== 72'd0 || req_ready !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_initial: got %h/%b required 0/000", obs_regs(), req_ready);
    end
    reset = 1'b1;
    req_valid = 3'b111;
    req_data  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    req_addr  = 9'($urandom);
    tick(acc);
    tick(acc);
    // Asynchronous assertion away from the clock edge, mid-traffic.
    reset = 1'b0;
    #1;
    n_tests++;
    if (obs_regs() !== 72'd0 || req_ready !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_async: got %h/%b required 0/000", obs_regs(), req_ready);
    end
    model_reset();
    req_valid = '0;
    #1;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick(acc);
      n_tests++;
      if (rf_wena !== 1'b0 || obs_regs() !== exp_regs()) begin
        n_fail++;
        $display("FAIL reset_idle_wena: got %h required %h", obs_regs(), exp_regs());
      end
    end
  endtask

  task automatic test_single();
    logic [2:0] acc;
    pulse_reset();
    req_valid = 3'b010;
    req_addr  = '0;
    req_addr[ADDR_W +: ADDR_W] = 3'd5;
    req_data  = '0;
    req_data[DATA_W +: DATA_W] = 64'hDEADBEEF_00000001;
    #1;
    n_tests++;
    if (req_ready !== 3'b010) begin
      n_fail++;
      $display("FAIL single_ready: got %b required 010", req_ready);
    end
    tick(acc);
    req_valid = '0;
    n_tests++;
    if (rf_waddr !== 3'd5 || rf_wdata !== 64'hDEADBEEF_00000001 || rf_wena !== 1'b1 ||
        grant_id !== 2'd1) begin
      n_fail++;
      $display("FAIL single_write: got a=%0d d=%h w=%b g=%0d required a=5 d=deadbeef00000001 w=1 g=1",
               rf_waddr, rf_wdata, rf_wena, grant_id);
    end
    tick(acc);
    n_tests++;
    if (rf_wena !== 1'b0) begin
      n_fail++;
      $display("FAIL single_after: got wena=%b required 0", rf_wena);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] acc;
    int cnt [NREQ];
    pulse_reset();
    for (int i = 0; i < NREQ; i++) cnt[i] = 0;
    req_valid = 3'b111;
    req_addr  = 9'($urandom);
    req_data  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    for (int c = 0; c < 6; c++) begin
      #1;
      n_tests++;
      if (req_ready !== 3'(1 << (c % 3))) begin
        n_fail++;
        $display("FAIL rr_ready[%0d]: got %b required %b", c, req_ready, 3'(1 << (c % 3)));
      end
      tick(acc);
      n_tests++;
      if (grant_id !== 2'(c % 3) || obs_regs() !== exp_regs()) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: got g=%0d regs=%h required g=%0d regs=%h",
                 c, grant_id, obs_regs(), c % 3, exp_regs());
      end
      if (rf_wena === 1'b1 && grant_id < 2'd3) cnt[grant_id]++;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) begin
          req_addr[i*ADDR_W +: ADDR_W] = 3'($urandom);
          req_data[i*DATA_W +: DATA_W] = {$urandom, $urandom};
        end
      end
    end
    req_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      n_tests++;
      if (cnt[i] != 2) begin
        n_fail++;
        $display("FAIL rr_count[%0d]: got %0d required 2", i, cnt[i]);
      end
    end
  endtask

  task automatic test_clear_contention();
    logic [2:0] acc;
    pulse_reset();
    req_valid   = 3'b101;
    req_addr    = 9'($urandom);
    req_data    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    clear_start = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 3'b000) begin
      n_fail++;
      $display("FAIL clr_no_grant: got %b required 000", req_ready);
    end
    tick(acc);
    clear_start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      logic [69:0] o, e;
      o = {rf_wena, rf_waddr, rf_wdata, clear_busy, clear_done};
      e = (c <= 8) ? {1'b1, 3'(c - 1), 64'd0, 1'b1, 1'b0} : {1'b0, 3'd7, 64'd0, 1'b0, 1'b1};
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL clr_cycle[N+%0d]: got %h required %h", c, o, e);
      end
      #1;
      n_tests++;
      if (req_ready !== ((c <= 8) ? 3'b000 : 3'b001)) begin
        n_fail++;
        $display("FAIL clr_ready[N+%0d]: got %b required %b", c, req_ready,
                 (c <= 8) ? 3'b000 : 3'b001);
      end
      tick(acc);
    end
    req_valid = '0;
    n_tests++;
    if (clear_done !== 1'b0 || grant_id !== 2'd0 || rf_wena !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_after: got done=%b g=%0d w=%b required done=0 g=0 w=1",
               clear_done, grant_id, rf_wena);
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic [2:0] acc;
    int writes, dones;
    pulse_reset();
    req_valid   = '0;
    clear_start = 1'b1;
    tick(acc);
    clear_start = 1'b0;
    for (int c = 0; c < 3; c++) tick(acc);
    reset = 1'b0;
    #1;
    n_tests++;
    if (clear_busy !== 1'b0 || clear_done !== 1'b0 || rf_wena !== 1'b0 || rf_waddr !== 3'd0) begin
      n_fail++;
      $display("FAIL midsweep_reset: got busy=%b done=%b w=%b a=%0d required 0 0 0 0",
               clear_busy, clear_done, rf_wena, rf_waddr);
    end
    model_reset();
    reset = 1'b1;
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      tick(acc);
      if (clear_done === 1'b1 || clear_busy === 1'b1) dones++;
    end
    n_tests++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL midsweep_no_done: got %0d busy/done cycles required 0", dones);
    end
    clear_start = 1'b1;
    tick(acc);
    clear_start = 1'b0;
    writes = 0; dones = 0;
    for (int c = 0; c < 12; c++) begin
      if (rf_wena === 1'b1) writes++;
      if (clear_done === 1'b1) dones++;
      n_tests++;
      if (obs_regs() !== exp_regs()) begin
        n_fail++;
        $display("FAIL restart_cycle[%0d]: got %h required %h", c, obs_regs(), exp_regs());
      end
      tick(acc);
    end
    n_tests++;
    if (writes != 8 || dones != 1) begin
      n_fail++;
      $display("FAIL restart_sweep: got writes=%0d dones=%0d required 8 1", writes, dones);
    end
  endtask

  task automatic test_ignored_clear();
    logic [2:0] acc;
    int writes, dones;
    pulse_reset();
    req_valid   = '0;
    clear_start = 1'b1;
    tick(acc);
    writes = 0; dones = 0;
    for (int c = 1; c <= 12; c++) begin
      clear_start = (c <= 6);
      if (rf_wena === 1'b1) writes++;
      if (clear_done === 1'b1) dones++;
      n_tests++;
      if (obs_regs() !== exp_regs()) begin
        n_fail++;
        $display("FAIL ignclr_cycle[N+%0d]: got %h required %h", c, obs_regs(), exp_regs());
      end
      tick(acc);
    end
    clear_start = 1'b0;
    n_tests++;
    if (writes != 8 || dones != 1) begin
      n_fail++;
      $display("FAIL ignclr_len: got writes=%0d dones=%0d required 8 1", writes, dones);
    end
  endtask

  task automatic test_random();
    logic [2:0] acc;
    bit pending [NREQ];
    pulse_reset();
    for (int i = 0; i < NREQ; i++) pending[i] = 0;
    req_valid = '0;
    for (int c = 0; c < 400; c++) begin
      n_tests++;
      if (obs_regs() !== exp_regs()) begin
        n_fail++;
        $display("FAIL rand_regs[%0d]: got %h required %h", c, obs_regs(), exp_regs());
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!pending[i] && ($urandom_range(1, 0) == 1)) begin
          pending[i] = 1;
          req_addr[i*ADDR_W +: ADDR_W] = 3'($urandom);
          req_data[i*DATA_W +: DATA_W] = {$urandom, $urandom};
        end
        req_valid[i] = pending[i];
      end
      clear_start = ($urandom_range(19, 0) == 0);
      #1;
      n_tests++;
      if (req_ready !== exp_ready()) begin
        n_fail++;
        $display("FAIL rand_ready[%0d]: got %b required %b", c, req_ready, exp_ready());
      end
      tick(acc);
      for (int i = 0; i < NREQ; i++) if (acc[i]) pending[i] = 0;
    end
    clear_start = 1'b0;
    req_valid   = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_clear_contention();
    test_reset_mid_sweep();
    test_ignored_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
